// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Captures one byte per frame, pulses the UART enable once, then follows busy through rise and fall.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned INPUT_DATA_WIDTH = 8,
  parameter int unsigned BUSY_TIMEOUT     = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req,
  input  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                    grant,
  output logic                                  uart_enable,
  output logic [INPUT_DATA_WIDTH-1:0]           uart_data,
  input  logic                                  uart_busy,
  output logic [$clog2(NUM_REQ)-1:0]            active_id,
  output logic                                  frame_active,
  output logic                                  timeout_err
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);
  // Counter value whose increment would reach BUSY_TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(BUSY_TIMEOUT - 2);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [NUM_REQ-1:0]          grant_q, grant_d;
  logic                        uart_enable_q, uart_enable_d;
  logic [INPUT_DATA_WIDTH-1:0] uart_data_q, uart_data_d;
  logic [ID_W-1:0]             active_id_q, active_id_d;
  logic                        frame_active_q, frame_active_d;
  logic                        timeout_err_q, timeout_err_d;
  logic [ID_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic                        sel_found;
  logic [ID_W-1:0]             sel_idx;

  // Circular search for the first requester at or after the rr pointer.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && req[ID_W'((32'(rr_ptr_q) + i) % NUM_REQ)]) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = '0;
    uart_enable_d  = 1'b0;
    uart_data_d    = uart_data_q;
    active_id_d    = active_id_q;
    frame_active_d = frame_active_q;
    timeout_err_d  = 1'b0;
    rr_ptr_d       = rr_ptr_q;
    cnt_d          = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (sel_found && !uart_busy) begin
          grant_d[sel_idx] = 1'b1;
          uart_enable_d    = 1'b1;
          uart_data_d      = req_data[32'(sel_idx)*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
          active_id_d      = sel_idx;
          frame_active_d   = 1'b1;
          state_d          = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rr_ptr_d = ID_W'((32'(active_id_q) + 32'd1) % NUM_REQ);
        cnt_d    = '0;
        state_d  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (uart_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // UART never acknowledged: drop the byte and free the transmitter.
          if (cnt_q == CNT_FIRE) begin
            timeout_err_d  = 1'b1;
            frame_active_d = 1'b0;
            state_d        = ST_IDLE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_busy) begin
          frame_active_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      uart_enable_q  <= 1'b0;
      uart_data_q    <= '0;
      active_id_q    <= '0;
      frame_active_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      rr_ptr_q       <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      uart_enable_q  <= uart_enable_d;
      uart_data_q    <= uart_data_d;
      active_id_q    <= active_id_d;
      frame_active_q <= frame_active_d;
      timeout_err_q  <= timeout_err_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
    end
  end

  assign grant        = grant_q;
  assign uart_enable  = uart_enable_q;
  assign uart_data    = uart_data_q;
  assign active_id    = active_id_q;
  assign frame_active = frame_active_q;
  assign timeout_err  = timeout_err_q;

endmodule
